// File: rtl/bpred_btb.sv
// bpred_btb: direct-mapped branch target buffer with saturating direction counters,
// zero-latency IF lookup, one-cycle resolution training, flush and saturating perf counters.
module bpred_btb #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int PERF_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_pred_pc,
  output logic              o_pred_hit,
  output logic              o_pred_taken,
  output logic [31:0]       o_pred_npc,
  input  logic              i_pred_en,
  input  logic              i_upd_en,
  input  logic [31:0]       i_upd_pc,
  input  logic              i_upd_taken,
  input  logic [31:0]       i_upd_target,
  input  logic              i_upd_mispred,
  input  logic              i_flush,
  output logic [PERF_W-1:0] o_perf_lookups,
  output logic [PERF_W-1:0] o_perf_mispred
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [CNT_W-1:0] r_cnt    [ENTRIES];
  logic [PERF_W-1:0] r_lookups, r_mispred;

  logic [IDX_W-1:0] w_pidx, w_uidx;
  logic [TAG_W-1:0] w_ptag, w_utag;
  logic             w_uhit;
  logic             w_unused;

  assign w_pidx   = i_pred_pc[IDX_W+1:2];
  assign w_ptag   = i_pred_pc[31:IDX_W+2];
  assign w_uidx   = i_upd_pc[IDX_W+1:2];
  assign w_utag   = i_upd_pc[31:IDX_W+2];
  assign w_uhit   = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_unused = ^{i_pred_pc[1:0], i_upd_pc[1:0]};

  // Lookup reads only stored state, so a same-cycle update shows up next cycle
  assign o_pred_hit     = r_valid[w_pidx] && (r_tag[w_pidx] == w_ptag);
  assign o_pred_taken   = o_pred_hit && r_cnt[w_pidx][CNT_W-1];
  assign o_pred_npc     = o_pred_taken ? r_target[w_pidx] : i_pred_pc + 32'd4;
  assign o_perf_lookups = r_lookups;
  assign o_perf_mispred = r_mispred;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int e = 0; e < ENTRIES; e++) begin
        r_valid[e]  <= 1'b0;
        r_tag[e]    <= '0;
        r_target[e] <= '0;
        r_cnt[e]    <= CNT_WNT;
      end
    end else if (i_flush) begin
      for (int e = 0; e < ENTRIES; e++) r_valid[e] <= 1'b0;
    end else if (i_upd_en) begin
      if (w_uhit) begin
        r_cnt[w_uidx] <= i_upd_taken ? ((r_cnt[w_uidx] == CNT_MAX) ? CNT_MAX : r_cnt[w_uidx] + 1'b1)
                                     : ((r_cnt[w_uidx] == '0) ? '0 : r_cnt[w_uidx] - 1'b1);
        if (i_upd_taken) r_target[w_uidx] <= i_upd_target;
      end else if (i_upd_taken) begin
        r_valid[w_uidx]  <= 1'b1;
        r_tag[w_uidx]    <= w_utag;
        r_target[w_uidx] <= i_upd_target;
        r_cnt[w_uidx]    <= CNT_WT;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lookups <= '0;
      r_mispred <= '0;
    end else begin
      if (i_pred_en && !(&r_lookups)) r_lookups <= r_lookups + 1'b1;
      if (i_upd_en && i_upd_mispred && !(&r_mispred)) r_mispred <= r_mispred + 1'b1;
    end
  end
endmodule

// File: tb/tb_bpred_btb.sv
// tb_bpred_btb: random and directed stimulus checked every cycle against a table model of the BTB.
module tb_bpred_btb;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 2;
  localparam int PERF_W  = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int CHALF   = 1 << (CNT_W - 1);
  localparam int PMAX    = (1 << PERF_W) - 1;

  logic clk = 0, rst = 1;
  logic [31:0] pred_pc = 0, upd_pc = 0, upd_target = 0;
  logic pred_en = 0, upd_en = 0, upd_taken = 0, upd_mispred = 0, flush = 0;
  logic pred_hit, pred_taken;
  logic [31:0] pred_npc;
  logic [PERF_W-1:0] perf_lookups, perf_mispred;

  bpred_btb #(.ENTRIES(ENTRIES), .CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_pred_pc(pred_pc), .o_pred_hit(pred_hit),
    .o_pred_taken(pred_taken), .o_pred_npc(pred_npc), .i_pred_en(pred_en),
    .i_upd_en(upd_en), .i_upd_pc(upd_pc), .i_upd_taken(upd_taken),
    .i_upd_target(upd_target), .i_upd_mispred(upd_mispred), .i_flush(flush),
    .o_perf_lookups(perf_lookups), .o_perf_mispred(perf_mispred));

  always #5 clk = ~clk;

  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_target[ENTRIES];
  int          m_cnt   [ENTRIES];
  int          m_lk, m_mp;

  int n_cmp = 0, n_bad = 0;
  logic lit_on = 0, lit_perf = 0, lit_hit = 0, lit_taken = 0;
  logic [31:0] lit_npc = 0;
  int lit_lk = 0, lit_mp = 0;
  string lit_nm = "";

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  task automatic model_reset();
    for (int e = 0; e < ENTRIES; e++) begin
      m_valid[e] = 0; m_tag[e] = 0; m_target[e] = 0; m_cnt[e] = CHALF - 1;
    end
    m_lk = 0; m_mp = 0;
  endtask

  task automatic model_step();
    int i;
    if (pred_en && m_lk < PMAX) m_lk++;
    if (upd_en && upd_mispred && m_mp < PMAX) m_mp++;
    if (flush) begin
      for (int e = 0; e < ENTRIES; e++) m_valid[e] = 0;
    end else if (upd_en) begin
      i = idx_of(upd_pc);
      if (m_valid[i] && m_tag[i] == tag_of(upd_pc)) begin
        if (upd_taken) begin
          if (m_cnt[i] < CMAX) m_cnt[i]++;
          m_target[i] = upd_target;
        end else if (m_cnt[i] > 0) m_cnt[i]--;
      end else if (upd_taken) begin
        m_valid[i] = 1; m_tag[i] = tag_of(upd_pc); m_target[i] = upd_target; m_cnt[i] = CHALF;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int i;
    logic e_hit, e_taken;
    if (!rst) begin
      i = idx_of(pred_pc);
      e_hit = m_valid[i] && m_tag[i] == tag_of(pred_pc);
      e_taken = e_hit && m_cnt[i] >= CHALF;
      chk("hit", 32'(pred_hit), 32'(e_hit));
      chk("taken", 32'(pred_taken), 32'(e_taken));
      chk("npc", pred_npc, e_taken ? m_target[i] : pred_pc + 32'd4);
      chk("perf_lookups", 32'(perf_lookups), m_lk);
      chk("perf_mispred", 32'(perf_mispred), m_mp);
      if (lit_on) begin
        chk({lit_nm, "_hit"}, 32'(pred_hit), 32'(lit_hit));
        chk({lit_nm, "_taken"}, 32'(pred_taken), 32'(lit_taken));
        chk({lit_nm, "_npc"}, pred_npc, lit_npc);
      end
      if (lit_perf) begin
        chk({lit_nm, "_lk"}, 32'(perf_lookups), lit_lk);
        chk({lit_nm, "_mp"}, 32'(perf_mispred), lit_mp);
      end
    end
  end

  task automatic cyc(input logic [31:0] pc, input logic pen, input logic uen,
                     input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                     input logic umis, input logic fl);
    pred_pc = pc; pred_en = pen; upd_en = uen; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_mispred = umis; flush = fl;
    @(negedge clk);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic upd(input logic [31:0] upc, input logic ut, input logic [31:0] utgt);
    cyc(32'h0, 0, 1, upc, ut, utgt, 0, 0);
  endtask

  task automatic look(input string nm, input logic [31:0] pc, input logic h,
                      input logic t, input logic [31:0] npc);
    lit_nm = nm; lit_hit = h; lit_taken = t; lit_npc = npc; lit_on = 1;
    cyc(pc, 0, 0, 0, 0, 0, 0, 0);
    lit_on = 0;
  endtask

  task automatic perf(input string nm, input int lk, input int mp);
    lit_nm = nm; lit_lk = lk; lit_mp = mp; lit_perf = 1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    lit_perf = 0;
  endtask

  initial begin
    model_reset();
    #12 rst = 0;
    look("reset", 32'h100, 0, 0, 32'h104);
    perf("reset_perf", 0, 0);
    upd(32'h100, 1, 32'h200);
    look("train", 32'h100, 1, 1, 32'h200);
    upd(32'h100, 0, 0);
    upd(32'h100, 0, 0);
    look("two_nt", 32'h100, 1, 0, 32'h104);
    repeat (5) upd(32'h100, 1, 32'h200);
    upd(32'h100, 0, 0);
    look("sat_hi", 32'h100, 1, 1, 32'h200);
    repeat (5) upd(32'h100, 0, 0);
    upd(32'h100, 1, 32'h200);
    look("sat_lo", 32'h100, 1, 0, 32'h104);
    upd(32'h140, 1, 32'h400);
    look("evicted", 32'h100, 0, 0, 32'h104);
    look("replaced", 32'h140, 1, 1, 32'h400);
    upd(32'h180, 0, 0);
    look("nt_miss", 32'h180, 0, 0, 32'h184);
    look("nt_keep", 32'h140, 1, 1, 32'h400);
    cyc(32'h0, 0, 1, 32'h300, 1, 32'h500, 0, 1);
    look("flush_upd", 32'h300, 0, 0, 32'h304);
    look("flush_all", 32'h140, 0, 0, 32'h144);
    upd(32'h0, 1, 32'h80);
    look("wrap", 32'hFFFF_FFFC, 0, 0, 32'h0);
    repeat (3) cyc(0, 0, 1, 32'h40, 0, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 32'h40, 0, 0, 1, 0);
    perf("mispred", 0, 3);
    repeat (20) cyc(0, 1, 0, 0, 0, 0, 0, 0);
    perf("lookups_sat", 15, 3);
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc, upc;
      pc  = ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
      upc = ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
      cyc(pc, 1'($urandom), 1'($urandom), upc, 1'($urandom), $urandom,
          1'($urandom), $urandom_range(0, 63) == 0);
    end
    upd(32'h100, 1, 32'h200);
    pred_pc = 32'h100; upd_en = 1; upd_pc = 32'h100; upd_taken = 1;
    upd_target = 32'h900; pred_en = 1;
    #2 rst = 1;
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    look("midrst", 32'h100, 0, 0, 32'h104);
    perf("midrst_perf", 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
